imem_loader: RTL and testbench

- Byte-stream program loader; the write side of the instruction memory. Receives a framed program image over a byte valid/ready channel (fed by the debug UART receiver) and emits one 32-bit write per assembled word into the instruction memory write port.
- Holds the CPU in reset (cpu_hold) while loading.
- Frame format: 2-byte word count N (LSB first), N x 4 data bytes (each word LSB first), 1 checksum byte equal to the XOR of all count and data bytes.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_byte_packer.sv | 38 +++
 rtl/imem_loader.sv | 125 ++++++++++++
 tb/tb_imem_loader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: memory geometry and
// the loader FSM state encoding.
package imem_loader_pkg;

  localparam int unsigned IMEM_BITS = 10;
  localparam int unsigned IMEM_SIZE = 1 << IMEM_BITS;

  typedef enum logic [2:0] {
    LD_IDLE = 3'd0,
    LD_LEN0 = 3'd1,
    LD_LEN1 = 3'd2,
    LD_DATA = 3'd3,
    LD_CSUM = 3'd4,
    LD_DONE = 3'd5,
    LD_ERR  = 3'd6
  } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs four accepted bytes (first byte in bits 7:0) into a 32-bit word and
// pulses word_valid for one cycle once the fourth byte is in.
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [1:0]  byte_idx,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [23:0] shift_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q    <= '0;
      byte_idx   <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        shift_q  <= '0;
        byte_idx <= '0;
      end else if (byte_valid) begin
        shift_q  <= {byte_data, shift_q[23:8]};
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) begin
          word_valid <= 1'b1;
          word_data  <= {byte_data, shift_q};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: parses count/data/checksum frames from the
// debug UART and writes assembled words into the instruction memory.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned IMEM_BITS = imem_loader_pkg::IMEM_BITS,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 rx_ready,
  output logic                 wr_en,
  output logic [IMEM_BITS-1:0] wr_addr,
  output logic [31:0]          wr_data,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 error,
  output logic [15:0]          words_loaded
);

  loader_state_t state_q, state_d;
  logic [15:0]   count_q;
  logic [7:0]    csum_q;
  logic [15:0]   len_full;
  logic          accept;
  logic          clear_pk;
  logic          pk_valid;
  logic [1:0]    byte_idx;
  logic          word_valid;
  logic [31:0]   word_data;

  assign rx_ready = (state_q == LD_LEN0) || (state_q == LD_LEN1) ||
                    (state_q == LD_DATA) || (state_q == LD_CSUM);
  assign accept   = rx_valid && rx_ready;
  assign len_full = {rx_data, count_q[7:0]};

  always_comb begin
    state_d  = state_q;
    clear_pk = 1'b0;
    pk_valid = 1'b0;
    case (state_q)
      LD_IDLE, LD_DONE, LD_ERR: begin
        if (start) begin
          state_d  = LD_LEN0;
          clear_pk = 1'b1;
        end
      end
      LD_LEN0: if (accept) state_d = LD_LEN1;
      LD_LEN1: begin
        if (accept) begin
          if (len_full > 16'(MAX_WORDS))  state_d = LD_ERR;
          else if (len_full == 16'd0)     state_d = LD_CSUM;
          else                            state_d = LD_DATA;
        end
      end
      LD_DATA: begin
        if (accept) begin
          pk_valid = 1'b1;
          // The previous word's write has always landed by the time the next
          // word completes, so words_loaded indexes the word being finished.
          if (byte_idx == 2'd3 && (words_loaded + 16'd1) == count_q)
            state_d = LD_CSUM;
        end
      end
      LD_CSUM: begin
        if (accept) state_d = (rx_data == csum_q) ? LD_DONE : LD_ERR;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= LD_IDLE;
      count_q      <= '0;
      csum_q       <= '0;
      words_loaded <= '0;
      wr_addr      <= '0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clear_pk) begin
        cpu_hold     <= 1'b1;
        done         <= 1'b0;
        error        <= 1'b0;
        words_loaded <= '0;
        csum_q       <= '0;
        count_q      <= '0;
      end
      if (accept && state_q != LD_CSUM) csum_q <= csum_q ^ rx_data;
      if (accept && state_q == LD_LEN0) count_q[7:0]  <= rx_data;
      if (accept && state_q == LD_LEN1) count_q[15:8] <= rx_data;
      if (pk_valid && byte_idx == 2'd3) wr_addr <= words_loaded[IMEM_BITS-1:0];
      if (word_valid) words_loaded <= words_loaded + 16'd1;
      if (state_d == LD_DONE && state_q != LD_DONE) begin
        cpu_hold <= 1'b0;
        done     <= 1'b1;
      end
      if (state_d == LD_ERR && state_q != LD_ERR) begin
        cpu_hold <= 1'b0;
        error    <= 1'b1;
      end
    end
  end

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear_pk),
    .byte_valid (pk_valid),
    .byte_data  (rx_data),
    .byte_idx   (byte_idx),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  assign wr_en   = word_valid;
  assign wr_data = word_data;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad checksum, oversize and empty
// frames, stalled input, ignored start and mid-frame reset.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int n_assert = 0;
  int n_fail   = 0;

  logic [9:0]  log_addr [16];
  logic [31:0] log_data [16];
  int          wr_cnt = 0;
  logic [7:0]  frame [$];

  imem_loader #(.IMEM_BITS(10), .MAX_WORDS(1024)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (wr_cnt < 16) begin
        log_addr[wr_cnt] = wr_addr;
        log_data[wr_cnt] = wr_data;
      end
      wr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    bit r;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 20; i++) begin
      r = rx_ready;
      @(posedge clk); #1;
      if (r) begin ok = 1'b1; break; end
    end
    rx_valid = 1'b0;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_range(input int from, input int to, input bit rnd);
    for (int i = from; i < to; i++)
      send_byte(frame[i], rnd ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // count 2, words 0x00000013 and 0x00100093, checksum = XOR of all bytes = 0x92
  task automatic load_good_frame(input logic [7:0] csum);
    frame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00, csum};
  endtask

  task automatic check_two_writes(input string p);
    check({p, "_wr_cnt"}, wr_cnt, 32'd2);
    check({p, "_addr0"}, {22'd0, log_addr[0]}, 32'd0);
    check({p, "_data0"}, log_data[0], 32'h0000_0013);
    check({p, "_addr1"}, {22'd0, log_addr[1]}, 32'd1);
    check({p, "_data1"}, log_data[1], 32'h0010_0093);
    check({p, "_words"}, {16'd0, words_loaded}, 32'd2);
  endtask

  task automatic check_good_result(input string p);
    check_two_writes(p);
    check({p, "_done"}, {31'd0, done}, 32'd1);
    check({p, "_error"}, {31'd0, error}, 32'd0);
    check({p, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    check({p, "_ready"}, {31'd0, rx_ready}, 32'd0);
    check({p, "_wr_en_idle"}, {31'd0, wr_en}, 32'd0);
    check({p, "_wr_addr_hold"}, {22'd0, wr_addr}, 32'd1);
    check({p, "_wr_data_hold"}, wr_data, 32'h0010_0093);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_cycles(2);
    check("rst_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_words", {16'd0, words_loaded}, 32'd0);
    check("rst_wr_addr", {22'd0, wr_addr}, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    reset = 1'b1;
    wait_cycles(1);
    check("idle_ready", {31'd0, rx_ready}, 32'd0);

    // Good frame, rx_valid held high
    load_good_frame(8'h92);
    wr_cnt = 0;
    pulse_start();
    check("s1_hold_on", {31'd0, cpu_hold}, 32'd1);
    check("s1_ready_on", {31'd0, rx_ready}, 32'd1);
    send_range(0, 11, 1'b0);
    wait_cycles(2);
    check_good_result("s1");

    // Same frame, bad checksum
    load_good_frame(8'h00);
    wr_cnt = 0;
    pulse_start();
    check("s2_done_clr", {31'd0, done}, 32'd0);
    send_range(0, 11, 1'b0);
    wait_cycles(2);
    check_two_writes("s2");
    check("s2_error", {31'd0, error}, 32'd1);
    check("s2_done", {31'd0, done}, 32'd0);
    check("s2_hold", {31'd0, cpu_hold}, 32'd0);

    // Count 1025 exceeds MAX_WORDS
    frame = '{8'h01, 8'h04};
    wr_cnt = 0;
    pulse_start();
    check("s3_error_clr", {31'd0, error}, 32'd0);
    send_range(0, 2, 1'b0);
    check("s3_error", {31'd0, error}, 32'd1);
    check("s3_ready", {31'd0, rx_ready}, 32'd0);
    check("s3_hold", {31'd0, cpu_hold}, 32'd0);
    wait_cycles(2);
    check("s3_wr_cnt", wr_cnt, 32'd0);
    check("s3_words", {16'd0, words_loaded}, 32'd0);

    // Empty frame
    frame = '{8'h00, 8'h00, 8'h00};
    wr_cnt = 0;
    pulse_start();
    send_range(0, 3, 1'b0);
    wait_cycles(2);
    check("s4_done", {31'd0, done}, 32'd1);
    check("s4_error", {31'd0, error}, 32'd0);
    check("s4_wr_cnt", wr_cnt, 32'd0);
    check("s4_words", {16'd0, words_loaded}, 32'd0);

    // Stalled input plus an ignored start pulse mid-DATA
    load_good_frame(8'h92);
    wr_cnt = 0;
    pulse_start();
    send_range(0, 7, 1'b1);
    pulse_start();
    check("s5_hold_mid", {31'd0, cpu_hold}, 32'd1);
    check("s5_ready_mid", {31'd0, rx_ready}, 32'd1);
    send_range(7, 11, 1'b1);
    wait_cycles(2);
    check_good_result("s5");

    // Reset after six data bytes, then reload
    load_good_frame(8'h92);
    wr_cnt = 0;
    pulse_start();
    send_range(0, 8, 1'b0);
    reset = 1'b0;
    #2;
    check("s6_rst_ready", {31'd0, rx_ready}, 32'd0);
    check("s6_rst_hold", {31'd0, cpu_hold}, 32'd0);
    check("s6_rst_words", {16'd0, words_loaded}, 32'd0);
    check("s6_rst_wr_data", wr_data, 32'd0);
    check("s6_rst_wr_addr", {22'd0, wr_addr}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    check("s6_partial_cnt", wr_cnt, 32'd1);
    check("s6_partial_addr", {22'd0, log_addr[0]}, 32'd0);
    check("s6_partial_data", log_data[0], 32'h0000_0013);
    wait_cycles(1);
    wr_cnt = 0;
    pulse_start();
    send_range(0, 11, 1'b0);
    wait_cycles(2);
    check_good_result("s6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
